fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the write port of the 8-deep async hit FIFO between NREQ requesters, e.g. pixel-column readout units in the FE-I4 emulator.
- Sits entirely in the write clock domain and drives the FIFO's winc/wdata directly.
- Honours wfull, which is derived from the synchronised read pointer.
- Grants bursts of up to MAX_BURST words per owner, then rotates ownership.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 24, data word width (one FE-I4 data record).
- MAX_BURST, 4, max words accepted from one owner per grant (1..255).

Ports:
- wclk  in  1  write-domain clock.
- wrst  in  1  synchronous active-high reset, sampled on rising wclk.
- req  in  NREQ  per-requester "word available"; must hold data stable until acked.
- req_data  in  NREQ*DW  flat data bus; requester i drives bits [i*DW +: DW].
- ack  out  NREQ  one-hot, combinational; word of requester i consumed at this wclk edge.
- wfull  in  1  FIFO full flag, write domain.
- winc  out  1  FIFO write strobe, combinational (= |ack).
- wdata  out  DW  FIFO write data, combinational mux of owner's req_data.
- busy  out  1  registered; high while in OWN.
- gnt_id  out  3  registered index of the current or last owner.
- stall_cnt  out  16  only present with ARB_STALL_CNT_EN.

Behaviour:
- Reset, on any wclk edge with wrst=1, overriding everything else:
  - state=IDLE, rr_ptr=0, gnt_id=0, burst_cnt=0, busy=0.
  - ack=0, winc=0, wdata=0.
  - Reset mid-burst drops ownership immediately; no ack is issued in the reset cycle.
- IDLE:
  - ack=0, winc=0, wdata=0.
  - If any req bit is set, select the first set bit scanning from rr_ptr upward with wrap: gnt_id<=winner, burst_cnt<=0, state<=OWN.
  - Arbitration latency: 1 cycle from req to first possible ack.
- OWN:
  - ack[gnt_id] = req[gnt_id] & ~wfull; all other ack bits 0.
  - wdata = req_data slice of gnt_id whenever state=OWN, regardless of wfull.
  - On ack: burst_cnt<=burst_cnt+1.
- OWN exit conditions (priority in this order):
  - req[gnt_id]=0 → state<=IDLE, no ack that cycle.
  - Ack with burst_cnt==MAX_BURST-1 → state<=IDLE.
  - On either exit: rr_ptr<=(gnt_id+1) mod NREQ.
- wfull=1 while in OWN: no ack; ownership and burst_cnt held. If the owner drops req while full, release as above.
- Re-arbitration always passes through IDLE, giving one bubble cycle between grants. Worst-case wait for requester i is (NREQ-1)*(MAX_BURST+1) cycles with wfull=0.
- Requests arriving in OWN from non-owners are ignored until the next IDLE evaluation.
- req bits at or above NREQ do not exist; gnt_id upper bits are zero when NREQ<8.
- MAX_BURST=1: exactly one word per grant, strict round-robin.

Optional Feature:
- Macro: ARB_STALL_CNT_EN.
- When defined:
  - stall_cnt port exists: a 16-bit saturating count of cycles with state=OWN & req[gnt_id]=1 & wfull=1.
  - Holds at 16'hFFFF; cleared only by wrst.
- When undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Single requester, wfull=0: reset, then req=4'b0001 held with data 24'h00000A,0B,0C,… → first ack 1 cycle after req. Four consecutive acks, winc=1, wdata=0A..0D. One idle cycle, then a new grant to the same requester.
- All four requesting, MAX_BURST=4, wfull=0: grant order 0,1,2,3,0. Each grant gives 4 acks; gnt_id sequence matches; exactly one bubble between bursts.
- Full stall: owner 2 mid-burst after 2 acks, wfull=1 for 5 cycles → ack=0, winc=0, gnt_id=2 held. stall_cnt=5 if enabled. After wfull falls, 2 more acks, then release.
- Early release: owner 1 drops req after 1 ack with req[3]=1 pending → IDLE next cycle, then gnt_id=3 (rr_ptr=2, scan 2→3).
- Reset mid-burst: wrst=1 during owner 0's 3rd word → same edge gives busy=0, ack=0, rr_ptr=0. After release, requester 0 wins first.
- Saturation (ARB_STALL_CNT_EN): owner held with wfull=1 for 70000 cycles → stall_cnt=16'hFFFF and stays.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters, the round-robin arbiter and the hit FIFO.
// The master modport is the arbiter side. The slave modport is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 24
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic               wfull;
    logic               winc;
    logic [DW-1:0]      wdata;

    modport master (
        input  req,
        input  req_data,
        input  wfull,
        output ack,
        output winc,
        output wdata
    );

    modport slave (
        output req,
        output req_data,
        output wfull,
        input  ack,
        input  winc,
        input  wdata
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter for the write port of the async hit FIFO (wclk domain).
// Optional ARB_STALL_CNT_EN adds a saturating count of owner cycles blocked by wfull.
//
//   state | meaning
//   IDLE  | no owner; scan req from rr_ptr upward (wrapping) and grant the first set bit
//   OWN   | gnt_id owns the FIFO write port; ack its words while not full, up to MAX_BURST
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 24,
    parameter int MAX_BURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    fifo_wr_arbiter_if.master     bus,
    output logic                  busy,
    output logic [2:0]            gnt_id
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);
    localparam logic [2:0] LAST_REQ  = 3'(NREQ - 1);

    state_t        state_q, state_nxt;
    logic [2:0]    rr_ptr_q, rr_nxt;
    logic [2:0]    gnt_nxt;
    logic [7:0]    burst_q, burst_nxt;

    logic          owner_req;
    logic [DW-1:0] owner_data;
    logic          found;
    logic [2:0]    winner;
    logic [2:0]    rr_after;
    logic          ack_one;
    logic [NREQ-1:0] ack_vec;
    logic [DW-1:0] wdata_c;

    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_id == 3'(k)) begin
                owner_req  = bus.req[k];
                owner_data = bus.req_data[k*DW +: DW];
            end
        end
    end

    // Wrapping scan done as two passes: rr_ptr..NREQ-1, then 0..rr_ptr-1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && (k >= int'(rr_ptr_q)) && bus.req[k]) begin
                found  = 1'b1;
                winner = 3'(k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found && (k < int'(rr_ptr_q)) && bus.req[k]) begin
                found  = 1'b1;
                winner = 3'(k);
            end
        end
    end

    assign rr_after = (gnt_id == LAST_REQ) ? 3'd0 : gnt_id + 3'd1;

    always_comb begin
        state_nxt = state_q;
        gnt_nxt   = gnt_id;
        rr_nxt    = rr_ptr_q;
        burst_nxt = burst_q;
        ack_one   = 1'b0;
        wdata_c   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = winner;
                    burst_nxt = '0;
                    state_nxt = OWN;
                end
            end
            OWN: begin
                wdata_c = owner_data;
                if (!owner_req) begin
                    state_nxt = IDLE;
                    rr_nxt    = rr_after;
                end else if (!bus.wfull) begin
                    ack_one   = 1'b1;
                    burst_nxt = burst_q + 8'd1;
                    if (burst_q == LAST_BEAT) begin
                        state_nxt = IDLE;
                        rr_nxt    = rr_after;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Reset cycle must not consume a word even though state is still OWN.
        if (wrst) begin
            ack_one = 1'b0;
            wdata_c = '0;
        end
    end

    always_comb begin
        ack_vec = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_id == 3'(k)) begin
                ack_vec[k] = ack_one;
            end
        end
    end

    assign bus.ack   = ack_vec;
    assign bus.winc  = ack_one;
    assign bus.wdata = wdata_c;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_id   <= '0;
            burst_q  <= '0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            rr_ptr_q <= rr_nxt;
            gnt_id   <= gnt_nxt;
            burst_q  <= burst_nxt;
            busy     <= (state_nxt == OWN);
        end
    end

`ifdef ARB_STALL_CNT_EN
    always_ff @(posedge wclk) begin
        if (wrst) begin
            stall_cnt <= '0;
        end else if ((state_q == OWN) && owner_req && bus.wfull && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DW=24, MAX_BURST=4); inputs are driven on
// the falling edge and outputs are checked 1 ns later, well away from the rising edge.
module tb_fifo_wr_arbiter;

    logic       wclk;
    logic       wrst;
    logic       busy;
    logic [2:0] gnt_id;
`ifdef ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter_if #(.NREQ(4), .DW(24)) bus ();

    fifo_wr_arbiter #(.NREQ(4), .DW(24), .MAX_BURST(4)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .bus       (bus.master),
        .busy      (busy),
        .gnt_id    (gnt_id)
`ifdef ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic b, input logic [2:0] g,
                           input logic [3:0] a, input logic [23:0] d);
        chk({tag, ".busy"},   32'(busy),      32'(b));
        chk({tag, ".gnt_id"}, 32'(gnt_id),    32'(g));
        chk({tag, ".ack"},    32'(bus.ack),   32'(a));
        chk({tag, ".winc"},   32'(bus.winc),  32'(|a));
        chk({tag, ".wdata"},  32'(bus.wdata), 32'(d));
    endtask

    task automatic set_data(input int i, input logic [23:0] v);
        bus.req_data[i*24 +: 24] = v;
    endtask

    task automatic next_cyc();
        @(negedge wclk);
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    logic [2:0] prev_g;

    initial begin
        wrst         = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.wfull    = 1'b0;
        repeat (2) next_cyc();
        #1;
        chk_out("reset", 1'b0, 3'd0, 4'b0000, 24'h0);
`ifdef ARB_STALL_CNT_EN
        chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        // Single requester: 1-cycle grant latency, 4-word burst, bubble, re-grant.
        next_cyc(); wrst = 1'b0; bus.req = 4'b0001; set_data(0, 24'h00000A); #1;
        chk_out("single.arb", 1'b0, 3'd0, 4'b0000, 24'h0);
        next_cyc(); #1;
        chk_out("single.w0", 1'b1, 3'd0, 4'b0001, 24'h00000A);
        next_cyc(); set_data(0, 24'h00000B); #1;
        chk_out("single.w1", 1'b1, 3'd0, 4'b0001, 24'h00000B);
        next_cyc(); set_data(0, 24'h00000C); #1;
        chk_out("single.w2", 1'b1, 3'd0, 4'b0001, 24'h00000C);
        next_cyc(); set_data(0, 24'h00000D); #1;
        chk_out("single.w3", 1'b1, 3'd0, 4'b0001, 24'h00000D);
        next_cyc(); set_data(0, 24'h00000E); #1;
        chk_out("single.bubble", 1'b0, 3'd0, 4'b0000, 24'h0);
        next_cyc(); #1;
        chk_out("single.regrant", 1'b1, 3'd0, 4'b0001, 24'h00000E);
        next_cyc(); bus.req = 4'b0000; #1;
        chk_out("single.drop", 1'b1, 3'd0, 4'b0000, 24'h00000E);
        next_cyc(); #1;
        chk_out("single.idle", 1'b0, 3'd0, 4'b0000, 24'h0);

        next_cyc(); wrst = 1'b1; #1;
        next_cyc(); wrst = 1'b0;

        // All four requesting: order 0,1,2,3,0 with one bubble per grant.
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 24'hA00000 + 24'(i));
        prev_g = 3'd0;
        #1;
        for (int n = 0; n < 5; n++) begin
            if (n != 0) next_cyc();
            #1;
            chk_out($sformatf("rr.bubble%0d", n), 1'b0, prev_g, 4'b0000, 24'h0);
            for (int w = 0; w < 4; w++) begin
                next_cyc(); #1;
                chk_out($sformatf("rr.g%0d.w%0d", n, w), 1'b1, 3'(order[n]),
                        4'(1 << order[n]), 24'hA00000 + 24'(order[n]));
            end
            prev_g = 3'(order[n]);
        end

        // Full stall: owner 2, two acks, five full cycles, two acks, release.
        next_cyc(); bus.req = 4'b0100; set_data(2, 24'h0000C0); #1;
        chk_out("stall.arb", 1'b0, 3'd0, 4'b0000, 24'h0);
        next_cyc(); #1;
        chk_out("stall.w0", 1'b1, 3'd2, 4'b0100, 24'h0000C0);
        next_cyc(); set_data(2, 24'h0000C1); #1;
        chk_out("stall.w1", 1'b1, 3'd2, 4'b0100, 24'h0000C1);
        next_cyc(); set_data(2, 24'h0000C2); bus.wfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) next_cyc();
            #1;
            chk_out($sformatf("stall.full%0d", c), 1'b1, 3'd2, 4'b0000, 24'h0000C2);
        end
        next_cyc(); bus.wfull = 1'b0; #1;
`ifdef ARB_STALL_CNT_EN
        chk("stall.stall_cnt", 32'(stall_cnt), 32'd5);
`endif
        chk_out("stall.w2", 1'b1, 3'd2, 4'b0100, 24'h0000C2);
        next_cyc(); set_data(2, 24'h0000C3); #1;
        chk_out("stall.w3", 1'b1, 3'd2, 4'b0100, 24'h0000C3);
        next_cyc(); bus.req = 4'b0000; #1;
        chk_out("stall.release", 1'b0, 3'd2, 4'b0000, 24'h0);

        next_cyc(); wrst = 1'b1; #1;
        next_cyc(); wrst = 1'b0;

        // Early release: owner 1 drops after one ack while requester 3 waits.
        bus.req = 4'b0010; set_data(1, 24'h0000B1); set_data(3, 24'h0000D3); #1;
        chk_out("early.arb", 1'b0, 3'd0, 4'b0000, 24'h0);
        next_cyc(); bus.req = 4'b1010; #1;
        chk_out("early.w0", 1'b1, 3'd1, 4'b0010, 24'h0000B1);
        next_cyc(); bus.req = 4'b1000; #1;
        chk_out("early.drop", 1'b1, 3'd1, 4'b0000, 24'h0000B1);
        next_cyc(); #1;
        chk_out("early.idle", 1'b0, 3'd1, 4'b0000, 24'h0);
        next_cyc(); #1;
        chk_out("early.g3", 1'b1, 3'd3, 4'b1000, 24'h0000D3);

        // Reset mid-burst: owner 0 loses the grant on its 3rd word.
        next_cyc(); bus.req = 4'b0000; #1;
        next_cyc(); bus.req = 4'b0011; set_data(0, 24'h000050); set_data(1, 24'h000051); #1;
        chk_out("rst.arb", 1'b0, 3'd3, 4'b0000, 24'h0);
        next_cyc(); #1;
        chk_out("rst.w0", 1'b1, 3'd0, 4'b0001, 24'h000050);
        next_cyc(); #1;
        chk_out("rst.w1", 1'b1, 3'd0, 4'b0001, 24'h000050);
        next_cyc(); wrst = 1'b1; #1;
        chk_out("rst.cycle", 1'b1, 3'd0, 4'b0000, 24'h0);
        next_cyc(); wrst = 1'b0; #1;
        chk_out("rst.after", 1'b0, 3'd0, 4'b0000, 24'h0);
        next_cyc(); #1;
        chk_out("rst.regrant", 1'b1, 3'd0, 4'b0001, 24'h000050);

`ifdef ARB_STALL_CNT_EN
        // Saturation: owner 0 blocked by wfull for 70000 cycles.
        bus.wfull = 1'b1;
        repeat (70000) next_cyc();
        #1;
        chk("sat.stall_cnt", 32'(stall_cnt), 32'h0000FFFF);
        chk_out("sat.hold", 1'b1, 3'd0, 4'b0000, 24'h000050);
        repeat (10) next_cyc();
        #1;
        chk("sat.stays", 32'(stall_cnt), 32'h0000FFFF);
        bus.wfull = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
